// File: rtl/hdmi_timing_pkg.sv
// Shared 640x480@60 timing defaults, the RGB888 pixel type and the colour-bar palette
// for the video timing generator.
package hdmi_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CW       = 11;

    typedef logic [23:0] rgb888_t;

    localparam rgb888_t RGB_WHITE   = 24'hFFFFFF;
    localparam rgb888_t RGB_YELLOW  = 24'hFFFF00;
    localparam rgb888_t RGB_CYAN    = 24'h00FFFF;
    localparam rgb888_t RGB_GREEN   = 24'h00FF00;
    localparam rgb888_t RGB_MAGENTA = 24'hFF00FF;
    localparam rgb888_t RGB_RED     = 24'hFF0000;
    localparam rgb888_t RGB_BLUE    = 24'h0000FF;
    localparam rgb888_t RGB_BLACK   = 24'h000000;

    typedef enum logic [2:0] {
        BAR_WHITE, BAR_YELLOW, BAR_CYAN, BAR_GREEN,
        BAR_MAGENTA, BAR_RED, BAR_BLUE, BAR_BLACK
    } bar_e;

    function automatic rgb888_t bar_color(input logic [2:0] idx);
        case (bar_e'(idx))
            BAR_WHITE:   return RGB_WHITE;
            BAR_YELLOW:  return RGB_YELLOW;
            BAR_CYAN:    return RGB_CYAN;
            BAR_GREEN:   return RGB_GREEN;
            BAR_MAGENTA: return RGB_MAGENTA;
            BAR_RED:     return RGB_RED;
            BAR_BLUE:    return RGB_BLUE;
            default:     return RGB_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/hdmi_video_timing_if.sv
// Pixel-request bus plus the timing/colour outputs that feed the TMDS encoder.
// master = timing generator, slave = pixel source / encoder side.
interface hdmi_video_timing_if
    import hdmi_timing_pkg::*;
#(
    parameter int CW = DEF_CW
);
    logic          pix_req;
    logic [CW-1:0] pix_x;
    logic [CW-1:0] pix_y;
    rgb888_t       rgb_in;
    logic          hsync;
    logic          vsync;
    logic          vde;
    logic [7:0]    red;
    logic [7:0]    green;
    logic [7:0]    blue;
    logic          frame_start;
    logic          line_start;

    modport master (
        output pix_req, pix_x, pix_y,
        output hsync, vsync, vde, red, green, blue, frame_start, line_start,
        input  rgb_in
    );

    modport slave (
        input  pix_req, pix_x, pix_y,
        input  hsync, vsync, vde, red, green, blue, frame_start, line_start,
        output rgb_in
    );
endinterface

// File: rtl/hdmi_color_bars.sv
// Eight vertical colour bars, each H_ACTIVE/8 pixels wide; output is registered so it
// lines up with the stage-1 pixel request. Used only when HDMI_TEST_PATTERN_EN is defined.
module hdmi_color_bars
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int CW       = DEF_CW
) (
    input  logic    pixel_clk,
    input  logic    reset,
    input  logic    active,
    input  logic    line_first,
    output rgb888_t color
);
    localparam int            BAR_W    = H_ACTIVE >> 3;
    localparam logic [CW-1:0] BAR_LAST = CW'(BAR_W - 1);

    logic [CW-1:0] width_q, width_d, width_cur;
    logic [2:0]    idx_q, idx_d, idx_cur;
    rgb888_t       color_q, color_d;

    // Column 0 of a line restarts the bar sequence without waiting for a register update.
    always_comb begin
        width_cur = line_first ? BAR_LAST : width_q;
        idx_cur   = line_first ? 3'd0 : idx_q;
        width_d   = width_q;
        idx_d     = idx_q;
        color_d   = RGB_BLACK;
        if (active) begin
            color_d = bar_color(idx_cur);
            if (width_cur == '0) begin
                width_d = BAR_LAST;
                idx_d   = idx_cur + 3'd1;
            end else begin
                width_d = width_cur - CW'(1);
                idx_d   = idx_cur;
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            width_q <= BAR_LAST;
            idx_q   <= 3'd0;
            color_q <= RGB_BLACK;
        end else begin
            width_q <= width_d;
            idx_q   <= idx_d;
            color_q <= color_d;
        end
    end

    assign color = color_q;
endmodule

// File: rtl/hdmi_video_timing.sv
// Video timing generator: counters -> registered pixel request -> registered TMDS controls.
// Optional colour-bar source is enabled by defining HDMI_TEST_PATTERN_EN.
module hdmi_video_timing
    import hdmi_timing_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter bit H_SYNC_POL = 1'b1,
    parameter bit V_SYNC_POL = 1'b1,
    parameter int CW         = DEF_CW
) (
    input logic                 pixel_clk,
    input logic                 reset,
    input logic                 enable,
    input logic                 test_mode,
    hdmi_video_timing_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_ACT_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END  = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_ACT_C = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END  = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [CW-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic          pix_req_q, pix_req_d;
    logic          hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d, ls1_q, ls1_d;
    logic          vde_q, vde_d;
    logic          hs2_q, hs2_d, vs2_q, vs2_d, fs2_q, fs2_d, ls2_q, ls2_d;
    logic          in_active, h_first, h_wrap, clr;
    rgb888_t       rgb_sel;

    // Disabling behaves exactly like reset so a mid-frame drop aborts cleanly.
    assign clr = reset || !enable;

    always_comb begin
        in_active = (h_cnt_q < H_ACT_C) && (v_cnt_q < V_ACT_C);
        h_first   = (h_cnt_q == '0);
        h_wrap    = (h_cnt_q == H_LAST);

        h_cnt_d = h_wrap ? '0 : h_cnt_q + CW'(1);
        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CW'(1);
        end

        pix_req_d = in_active;
        pix_x_d   = in_active ? h_cnt_q : pix_x_q;
        pix_y_d   = in_active ? v_cnt_q : pix_y_q;
        hs1_d     = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
        vs1_d     = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
        fs1_d     = in_active && h_first && (v_cnt_q == '0);
        ls1_d     = in_active && h_first;

        vde_d = pix_req_q;
        hs2_d = hs1_q;
        vs2_d = vs1_q;
        fs2_d = fs1_q;
        ls2_d = ls1_q;
    end

    always_ff @(posedge pixel_clk) begin
        if (clr) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            pix_req_q <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            fs1_q     <= 1'b0;
            ls1_q     <= 1'b0;
            vde_q     <= 1'b0;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
            fs2_q     <= 1'b0;
            ls2_q     <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            pix_req_q <= pix_req_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            fs1_q     <= fs1_d;
            ls1_q     <= ls1_d;
            vde_q     <= vde_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
            fs2_q     <= fs2_d;
            ls2_q     <= ls2_d;
        end
    end

`ifdef HDMI_TEST_PATTERN_EN
    rgb888_t bar1_color;
    rgb888_t bar2_q, bar2_d;

    hdmi_color_bars #(
        .H_ACTIVE (H_ACTIVE),
        .CW       (CW)
    ) u_color_bars (
        .pixel_clk  (pixel_clk),
        .reset      (clr),
        .active     (in_active),
        .line_first (h_first),
        .color      (bar1_color)
    );

    // Extra stage keeps the bars level with rgb_in, which arrives one cycle after pix_req.
    always_comb bar2_d = bar1_color;

    always_ff @(posedge pixel_clk) begin
        if (clr) bar2_q <= RGB_BLACK;
        else     bar2_q <= bar2_d;
    end

    assign rgb_sel = test_mode ? bar2_q : vid.rgb_in;
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
    assign rgb_sel          = vid.rgb_in;
`endif

    assign vid.pix_req     = pix_req_q;
    assign vid.pix_x       = pix_x_q;
    assign vid.pix_y       = pix_y_q;
    assign vid.vde         = vde_q;
    assign vid.frame_start = fs2_q;
    assign vid.line_start  = ls2_q;
    assign vid.hsync       = H_SYNC_POL ? hs2_q : ~hs2_q;
    assign vid.vsync       = V_SYNC_POL ? vs2_q : ~vs2_q;
    assign vid.red         = vde_q ? rgb_sel[23:16] : 8'h00;
    assign vid.green       = vde_q ? rgb_sel[15:8]  : 8'h00;
    assign vid.blue        = vde_q ? rgb_sel[7:0]   : 8'h00;
endmodule

// File: tb/tb_hdmi_video_timing.sv
// Directed bench for hdmi_video_timing: 640-wide lines with a short 22-line frame so a
// full frame fits in a small cycle budget; an echo pixel source returns {x, y, 8'h5A}.
module tb_hdmi_video_timing;
    import hdmi_timing_pkg::*;

    localparam int HA = 640, HFP = 16, HS = 96, HBP = 48;
    localparam int VA = 16, VFP = 2, VS = 2, VBP = 2;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;
    localparam int FRAME = HT * VT;
    localparam int CW = 11;

    logic pixel_clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic test_mode = 1'b0;
    rgb888_t rgb_src = '0;

    int total = 0;
    int bad = 0;
    int k, h, v;
    int err_vde, err_hs, err_vs, err_ls, err_rgb;
    int cnt_vde, cnt_hs, cnt_vs, cnt_ls, leak;
    int vde_fall, hs_rise, hs_fall;
    logic done;
    logic exp_vde;
    logic [7:0] hb, vb;
    rgb888_t exp_rgb;

    hdmi_video_timing_if #(.CW(CW)) vid ();

    hdmi_video_timing #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HS), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VS), .V_BP (VBP),
        .H_SYNC_POL (1'b1), .V_SYNC_POL (1'b1), .CW (CW)
    ) dut (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .enable    (enable),
        .test_mode (test_mode),
        .vid       (vid)
    );

    always #5 pixel_clk = ~pixel_clk;

    always @(posedge pixel_clk) rgb_src <= {vid.pix_x[7:0], vid.pix_y[7:0], 8'h5A};
    assign vid.rgb_in = rgb_src;

    task automatic step();
        @(posedge pixel_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_vde"}, 32'(vid.vde), 32'(0));
        check({tag, "_pix_req"}, 32'(vid.pix_req), 32'(0));
        check({tag, "_rgb"}, 32'({vid.red, vid.green, vid.blue}), 32'(0));
        check({tag, "_hsync"}, 32'(vid.hsync), 32'(0));
        check({tag, "_vsync"}, 32'(vid.vsync), 32'(0));
        check({tag, "_fs"}, 32'(vid.frame_start), 32'(0));
        check({tag, "_ls"}, 32'(vid.line_start), 32'(0));
        check({tag, "_pix_xy"}, 32'({vid.pix_x, vid.pix_y}), 32'(0));
    endtask

    function automatic int busy();
        return int'(vid.vde | vid.pix_req | vid.frame_start | vid.line_start | vid.hsync | vid.vsync);
    endfunction

    initial begin
        // Reset for 5 cycles
        for (int i = 0; i < 5; i++) step();
        check_idle("reset");
        $display("reset: checked idle outputs");

        // Start: frame_start appears on the second edge after enable goes high
        reset = 1'b0;
        enable = 1'b1;
        step();
        check("fs_first_edge", 32'(vid.frame_start), 32'(0));
        step();
        check("fs_second_edge", 32'(vid.frame_start), 32'(1));
        check("vde_at_origin", 32'(vid.vde), 32'(1));

        // Full frame against a cycle-by-cycle timing model
        k = 0; done = 1'b0;
        err_vde = 0; err_hs = 0; err_vs = 0; err_ls = 0; err_rgb = 0;
        cnt_vde = 0; cnt_hs = 0; cnt_vs = 0; cnt_ls = 0;
        vde_fall = -1; hs_rise = -1; hs_fall = -1;
        while (!done) begin
            h = k % HT;
            v = k / HT;
            hb = 8'(h);
            vb = 8'(v);
            exp_vde = (h < HA) && (v < VA);
            exp_rgb = exp_vde ? {hb, vb, 8'h5A} : 24'h0;
            if (vid.vde !== exp_vde) err_vde++;
            if (vid.hsync !== ((h >= HA + HFP) && (h < HA + HFP + HS))) err_hs++;
            if (vid.vsync !== ((v >= VA + VFP) && (v < VA + VFP + VS))) err_vs++;
            if (vid.line_start !== (exp_vde && (h == 0))) err_ls++;
            if ({vid.red, vid.green, vid.blue} !== exp_rgb) err_rgb++;
            if (vid.vde === 1'b1) cnt_vde++;
            if (vid.hsync === 1'b1) cnt_hs++;
            if (vid.vsync === 1'b1) cnt_vs++;
            if (vid.line_start === 1'b1) cnt_ls++;
            if (k > 0 && k < HT && vde_fall < 0 && vid.vde === 1'b0) vde_fall = k;
            if (k < HT && hs_rise < 0 && vid.hsync === 1'b1) hs_rise = k;
            if (hs_rise >= 0 && hs_fall < 0 && vid.hsync === 1'b0) hs_fall = k;
            if (k == 12 * HT + 37) begin
                check("echo_red_37_12", 32'(vid.red), 32'(37));
                check("echo_green_37_12", 32'(vid.green), 32'(12));
                check("echo_blue_37_12", 32'(vid.blue), 32'h5A);
            end
            if (k == 700) check("pix_xy_hold_blank", 32'({vid.pix_x, vid.pix_y}), 32'({11'd639, 11'd0}));
            step();
            k++;
            if (vid.frame_start === 1'b1 || k > 2 * FRAME) done = 1'b1;
        end
        check("frame_period", 32'(k), 32'(FRAME));
        check("vde_count", 32'(cnt_vde), 32'(HA * VA));
        check("hsync_count", 32'(cnt_hs), 32'(HS * VT));
        check("vsync_count", 32'(cnt_vs), 32'(VS * HT));
        check("line_start_count", 32'(cnt_ls), 32'(VA));
        check("vde_model_errs", 32'(err_vde), 32'(0));
        check("hsync_model_errs", 32'(err_hs), 32'(0));
        check("vsync_model_errs", 32'(err_vs), 32'(0));
        check("ls_model_errs", 32'(err_ls), 32'(0));
        check("rgb_model_errs", 32'(err_rgb), 32'(0));
        check("vde_fall_pos", 32'(vde_fall), 32'(HA));
        check("hsync_after_vde", 32'(hs_rise - vde_fall), 32'(HFP));
        check("hsync_width", 32'(hs_fall - hs_rise), 32'(HS));
        $display("frame: period=%0d vde=%0d hsync=%0d vsync=%0d", k, cnt_vde, cnt_hs, cnt_vs);

        // Drop enable at pixel (300,10) of the next frame
        for (int i = 0; i < 10 * HT + 300; i++) step();
        check("pre_drop_vde", 32'(vid.vde), 32'(1));
        check("pre_drop_red", 32'(vid.red), 32'(300 % 256));
        check("pre_drop_green", 32'(vid.green), 32'(10));
        enable = 1'b0;
        step();
        check_idle("enable_drop");
        for (int i = 0; i < 3; i++) step();
        enable = 1'b1;
        step();
        check("reen_fs_first_edge", 32'(vid.frame_start), 32'(0));
        step();
        check("reen_fs_second_edge", 32'(vid.frame_start), 32'(1));
        check("reen_rgb_origin", 32'({vid.red, vid.green, vid.blue}), 32'h00005A);
        $display("enable: drop at (300,10) and restart checked");

        // Reset mid-line
        for (int i = 0; i < 100; i++) step();
        check("pre_reset_red", 32'(vid.red), 32'(100));
        reset = 1'b1;
        step();
        check_idle("mid_reset");
        leak = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            leak += busy();
        end
        reset = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            leak += busy();
        end
        check("post_reset_leak", 32'(leak), 32'(0));
        $display("reset: mid-line reset checked");

`ifdef HDMI_TEST_PATTERN_EN
        // Colour bars
        test_mode = 1'b1;
        enable = 1'b1;
        step();
        step();
        check("bars_fs", 32'(vid.frame_start), 32'(1));
        check("bar_x0", 32'({vid.red, vid.green, vid.blue}), 32'hFFFFFF);
        for (int i = 0; i < 80; i++) step();
        check("bar_x80", 32'({vid.red, vid.green, vid.blue}), 32'hFFFF00);
        for (int i = 0; i < 80; i++) step();
        check("bar_x160", 32'({vid.red, vid.green, vid.blue}), 32'h00FFFF);
        for (int i = 0; i < 320; i++) step();
        check("bar_x480", 32'({vid.red, vid.green, vid.blue}), 32'h0000FF);
        for (int i = 0; i < 159; i++) step();
        check("bar_x639_vde", 32'(vid.vde), 32'(1));
        check("bar_x639", 32'({vid.red, vid.green, vid.blue}), 32'h000000);
        for (int i = 0; i < 61; i++) step();
        check("bar_blank", 32'({vid.red, vid.green, vid.blue}), 32'h000000);
        for (int i = 0; i < 100; i++) step();
        check("bar_line1_x0", 32'({vid.red, vid.green, vid.blue}), 32'hFFFFFF);
        $display("bars: colour bar positions checked");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
